// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle RV32I control unit. Steps every instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath selects
// and enables from the current state and the instruction register fields.
// Supports the R, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, AUIPC and LUI
// classes. Memory handshakes may be guarded by a timeout. Unknown opcodes,
// reserved branch funct3 values and memory timeouts enter a sticky trap
// state that only reset leaves.
//
// Parameters
//   MEM_TIMEOUT  max cycles spent waiting on imem_ready/dmem_ready before a
//                trap is raised; 0 waits forever
//   CNT_W        width of retired_cnt (only used with PERF_CNT_EN)
//
// Optional build macro
//   PERF_CNT_EN  adds the retired_cnt output, a counter of pc_we pulses
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   opcode       IR[6:0], held stable by the datapath after FETCH
//   funct3       IR[14:12]
//   funct7_5     IR[30]
//   alu_flags    [0] zero, [1] MSB, [2] overflow, [3] carry (no borrow)
//   imem_ready   instruction memory data valid
//   dmem_ready   data memory access complete
//   imem_re      instruction fetch request
//   ir_we        latch IR and pc_old
//   pc_we        update PC
//   pc_src       0 pc_old+4, 1 pc_old+imm, 2 ALU result
//   alu_a_src    0 rs1, 1 pc_old, 2 zero
//   alu_b_src    0 rs2, 1 imm
//   alu_cmd      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//                8 SLT, 9 SLTU
//   d_mem_re     data read request
//   d_mem_we     data write request
//   rf_we        register file write
//   rf_src       0 ALU, 1 memory data, 2 pc_old+4
//   trap         sticky fault indicator
//   trap_cause   01 illegal instruction, 10 memory timeout
//   retired_cnt  retired instruction count (PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic [3:0]       alu_flags,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_re,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_a_src,
   output logic             alu_b_src,
   output logic [3:0]       alu_cmd,
   output logic             d_mem_re,
   output logic             d_mem_we,
   output logic             rf_we,
   output logic [1:0]       rf_src,
   output logic             trap,
   output logic [1:0]       trap_cause
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] retired_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CL_R,
      CL_OPIMM,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_JALR,
      CL_AUIPC,
      CL_LUI,
      CL_BAD
   } iclass_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // The wait counter never has to hold more than MEM_TIMEOUT-1.
   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t          state;
   iclass_t         iclass;
   alu_t            alu_op;
   logic            br_taken;
   logic            br_illegal;
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;
   logic [1:0]      cause_q;

   logic flag_zero;
   logic flag_msb;
   logic flag_ovf;
   logic flag_carry;

   assign flag_zero  = alu_flags[0];
   assign flag_msb   = alu_flags[1];
   assign flag_ovf   = alu_flags[2];
   assign flag_carry = alu_flags[3];

   // Map the raw opcode onto an instruction class; anything outside the
   // RV32I base set is flagged so DECODE can trap on it.
   always_comb begin
      iclass = CL_BAD;
      case (opcode)
         OP_R:      iclass = CL_R;
         OP_OPIMM:  iclass = CL_OPIMM;
         OP_LOAD:   iclass = CL_LOAD;
         OP_STORE:  iclass = CL_STORE;
         OP_BRANCH: iclass = CL_BRANCH;
         OP_JAL:    iclass = CL_JAL;
         OP_JALR:   iclass = CL_JALR;
         OP_AUIPC:  iclass = CL_AUIPC;
         OP_LUI:    iclass = CL_LUI;
         default:   iclass = CL_BAD;
      endcase
   end

   // ALU operation for R and OP-IMM. funct7_5 selects SUB only for R-type,
   // since for ADDI that bit is part of the immediate; for shifts right it
   // selects SRA/SRAI in both classes.
   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000: begin
            if ((iclass == CL_R) && funct7_5) begin
               alu_op = ALU_SUB;
            end
         end
         3'b001: alu_op = ALU_SLL;
         3'b010: alu_op = ALU_SLT;
         3'b011: alu_op = ALU_SLTU;
         3'b100: alu_op = ALU_XOR;
         3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110: alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   // Branch condition from the flags of rs1 - rs2. Signed less-than is
   // MSB xor overflow; unsigned less-than is a borrow, i.e. carry clear.
   always_comb begin
      br_taken   = 1'b0;
      br_illegal = 1'b0;
      case (funct3)
         3'b000:  br_taken = flag_zero;
         3'b001:  br_taken = ~flag_zero;
         3'b100:  br_taken = flag_msb ^ flag_ovf;
         3'b101:  br_taken = ~(flag_msb ^ flag_ovf);
         3'b110:  br_taken = ~flag_carry;
         3'b111:  br_taken = flag_carry;
         default: br_illegal = 1'b1;
      endcase
   end

   // The limit is reached on the last allowed waiting cycle; a ready seen in
   // that same cycle still completes the access.
   assign to_hit = (MEM_TIMEOUT > 0) && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

   // State sequencing, the wait counter and the sticky trap cause. The
   // counter only advances while stalled in FETCH or MEM and restarts from
   // zero whenever the state changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         to_cnt  <= '0;
         cause_q <= 2'b00;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  state  <= S_DECODE;
                  to_cnt <= '0;
               end else if (to_hit) begin
                  state   <= S_TRAP;
                  cause_q <= CAUSE_TIMEOUT;
                  to_cnt  <= '0;
               end else if (MEM_TIMEOUT > 0) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               to_cnt <= '0;
               if (iclass == CL_BAD) begin
                  state   <= S_TRAP;
                  cause_q <= CAUSE_ILLEGAL;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               to_cnt <= '0;
               case (iclass)
                  CL_BRANCH: begin
                     if (br_illegal) begin
                        state   <= S_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
                  CL_LOAD, CL_STORE: state <= S_MEM;
                  default:           state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state  <= (iclass == CL_LOAD) ? S_WB : S_FETCH;
                  to_cnt <= '0;
               end else if (to_hit) begin
                  state   <= S_TRAP;
                  cause_q <= CAUSE_TIMEOUT;
                  to_cnt  <= '0;
               end else if (MEM_TIMEOUT > 0) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_WB: begin
               state  <= S_FETCH;
               to_cnt <= '0;
            end
            S_TRAP: begin
               state  <= S_TRAP;
               to_cnt <= '0;
            end
            default: begin
               state  <= S_TRAP;
               to_cnt <= '0;
            end
         endcase
      end
   end

   // Datapath controls. Everything is forced to zero while reset is held,
   // because the state register already sits in FETCH during reset.
   always_comb begin
      imem_re    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      alu_a_src  = 2'd0;
      alu_b_src  = 1'b0;
      alu_cmd    = ALU_ADD;
      d_mem_re   = 1'b0;
      d_mem_we   = 1'b0;
      rf_we      = 1'b0;
      rf_src     = 2'd0;
      trap       = 1'b0;
      trap_cause = 2'b00;
      if (rst_n) begin
         trap_cause = cause_q;
         case (state)
            S_FETCH: begin
               imem_re = 1'b1;
               ir_we   = imem_ready;
            end
            S_EXEC: begin
               case (iclass)
                  CL_R: begin
                     alu_cmd = alu_op;
                  end
                  CL_OPIMM: begin
                     alu_cmd   = alu_op;
                     alu_b_src = 1'b1;
                  end
                  CL_LOAD, CL_STORE, CL_JALR: begin
                     alu_b_src = 1'b1;
                  end
                  CL_AUIPC: begin
                     alu_a_src = 2'd1;
                     alu_b_src = 1'b1;
                  end
                  CL_LUI: begin
                     alu_a_src = 2'd2;
                     alu_b_src = 1'b1;
                  end
                  CL_BRANCH: begin
                     // A reserved funct3 traps without retiring, so no PC update.
                     if (!br_illegal) begin
                        alu_cmd = ALU_SUB;
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? 2'd1 : 2'd0;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            S_MEM: begin
               if (iclass == CL_LOAD) begin
                  d_mem_re = 1'b1;
               end else begin
                  d_mem_we = 1'b1;
                  pc_we    = dmem_ready;
               end
            end
            S_WB: begin
               rf_we = 1'b1;
               pc_we = 1'b1;
               case (iclass)
                  CL_LOAD: rf_src = 2'd1;
                  CL_JAL: begin
                     rf_src = 2'd2;
                     pc_src = 2'd1;
                  end
                  CL_JALR: begin
                     rf_src = 2'd2;
                     pc_src = 2'd2;
                  end
                  default: begin
                  end
               endcase
            end
            S_TRAP: begin
               trap = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PERF_CNT_EN
   // Every retired instruction produces exactly one pc_we pulse; pc_we is
   // never raised in TRAP, so the count freezes there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= '0;
      end else if (pc_we) begin
         retired_cnt <= retired_cnt + 1'b1;
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. Each instruction is expanded by a
// behavioural model into a per-cycle list of (inputs, expected outputs);
// the list is driven into the DUT and the sampled outputs compared.
// Branch flags and the expected branch outcome are derived from random
// 32-bit operands using plain comparisons.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int TO = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7_5;
   logic [3:0]    alu_flags;
   logic          imem_ready;
   logic          dmem_ready;
   logic          imem_re;
   logic          ir_we;
   logic          pc_we;
   logic [1:0]    pc_src;
   logic [1:0]    alu_a_src;
   logic          alu_b_src;
   logic [3:0]    alu_cmd;
   logic          d_mem_re;
   logic          d_mem_we;
   logic          rf_we;
   logic [1:0]    rf_src;
   logic          trap;
   logic [1:0]    trap_cause;
`ifdef PERF_CNT_EN
   logic [CW-1:0] retired_cnt;
`endif

   always #5 clk = ~clk;

   multicycle_ctrl #(
      .MEM_TIMEOUT(TO),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .alu_flags (alu_flags),
      .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .imem_re   (imem_re),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .alu_a_src (alu_a_src),
      .alu_b_src (alu_b_src),
      .alu_cmd   (alu_cmd),
      .d_mem_re  (d_mem_re),
      .d_mem_we  (d_mem_we),
      .rf_we     (rf_we),
      .rf_src    (rf_src),
      .trap      (trap),
      .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
      ,
      .retired_cnt(retired_cnt)
`endif
   );

   typedef struct packed {
      logic       imem_re;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic [1:0] alu_a_src;
      logic       alu_b_src;
      logic [3:0] alu_cmd;
      logic       d_mem_re;
      logic       d_mem_we;
      logic       rf_we;
      logic [1:0] rf_src;
      logic       trap;
      logic [1:0] trap_cause;
   } snap_t;

   typedef enum int {K_R, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR,
                     K_AUIPC, K_LUI, K_BAD} kind_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] f3;
      logic       f75;
      logic [3:0] flags;
      logic       imr;
      logic       dmr;
      logic       care;
      snap_t      exp;
   } step_t;

   step_t exp_q[$];
   snap_t obs_q[$];
   int    n_checks    = 0;
   int    n_fail      = 0;
   int    exp_retired = 0;

   function automatic logic [6:0] kind_op(kind_t k);
      case (k)
         K_R:      return 7'b0110011;
         K_OPIMM:  return 7'b0010011;
         K_LOAD:   return 7'b0000011;
         K_STORE:  return 7'b0100011;
         K_BRANCH: return 7'b1100011;
         K_JAL:    return 7'b1101111;
         K_JALR:   return 7'b1100111;
         K_AUIPC:  return 7'b0010111;
         K_LUI:    return 7'b0110111;
         default:  return 7'b1111111;
      endcase
   endfunction

   // ALU command table: mnemonic chosen by funct3, SUB only for R-type.
   function automatic logic [3:0] exp_alu(kind_t k, logic [2:0] f3, logic f75);
      case (f3)
         3'd0:    return (k == K_R && f75) ? 4'd1 : 4'd0;
         3'd1:    return 4'd5;
         3'd2:    return 4'd8;
         3'd3:    return 4'd9;
         3'd4:    return 4'd4;
         3'd5:    return f75 ? 4'd7 : 4'd6;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic snap_t sample();
      snap_t s;
      s.imem_re    = imem_re;
      s.ir_we      = ir_we;
      s.pc_we      = pc_we;
      s.pc_src     = pc_src;
      s.alu_a_src  = alu_a_src;
      s.alu_b_src  = alu_b_src;
      s.alu_cmd    = alu_cmd;
      s.d_mem_re   = d_mem_re;
      s.d_mem_we   = d_mem_we;
      s.rf_we      = rf_we;
      s.rf_src     = rf_src;
      s.trap       = trap;
      s.trap_cause = trap_cause;
      return s;
   endfunction

   task automatic push_step(input kind_t k, input logic [2:0] f3, input logic f75,
                            input logic [3:0] fl, input logic imr, input logic dmr,
                            input logic care, input snap_t e);
      step_t s;
      s.opcode = kind_op(k);
      s.f3     = f3;
      s.f75    = f75;
      s.flags  = fl;
      s.imr    = imr;
      s.dmr    = dmr;
      s.care   = care;
      s.exp    = e;
      exp_q.push_back(s);
   endtask

   // Reference model: expands one instruction into its cycle sequence.
   // fw = fetch wait cycles, mw = memory wait cycles (negative: never ready).
   task automatic add_instr(input kind_t k, input logic [2:0] f3, input logic f75,
                            input logic [3:0] fl, input int fw, input int mw,
                            input logic taken);
      snap_t e;
      int    n;
      for (int i = 0; i < fw; i++) begin
         e = '0; e.imem_re = 1'b1;
         push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
      end
      e = '0; e.imem_re = 1'b1; e.ir_we = 1'b1;
      push_step(k, f3, f75, fl, 1'b1, 1'b0, 1'b1, e);
      e = '0;
      push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
      if (k == K_BAD) return;
      e = '0;
      case (k)
         K_R:                     e.alu_cmd = exp_alu(k, f3, f75);
         K_OPIMM:                 begin e.alu_cmd = exp_alu(k, f3, f75); e.alu_b_src = 1'b1; end
         K_LOAD, K_STORE, K_JALR: e.alu_b_src = 1'b1;
         K_AUIPC:                 begin e.alu_a_src = 2'd1; e.alu_b_src = 1'b1; end
         K_LUI:                   begin e.alu_a_src = 2'd2; e.alu_b_src = 1'b1; end
         default:                 ;
      endcase
      if (k == K_BRANCH) begin
         if (f3 == 3'b010 || f3 == 3'b011) begin
            push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b0, e);
            return;
         end
         e.alu_cmd = 4'd1; e.pc_we = 1'b1; e.pc_src = taken ? 2'd1 : 2'd0;
         push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
         exp_retired++;
         return;
      end
      push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
      if (k == K_LOAD || k == K_STORE) begin
         n = (mw < 0) ? TO : mw;
         for (int i = 0; i < n; i++) begin
            e = '0;
            if (k == K_LOAD) e.d_mem_re = 1'b1; else e.d_mem_we = 1'b1;
            push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
         end
         if (mw < 0) return;
         e = '0;
         if (k == K_STORE) begin
            e.d_mem_we = 1'b1; e.pc_we = 1'b1;
            push_step(k, f3, f75, fl, 1'b0, 1'b1, 1'b1, e);
            exp_retired++;
            return;
         end
         e.d_mem_re = 1'b1;
         push_step(k, f3, f75, fl, 1'b0, 1'b1, 1'b1, e);
      end
      e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1;
      if (k == K_LOAD) e.rf_src = 2'd1;
      if (k == K_JAL)  begin e.rf_src = 2'd2; e.pc_src = 2'd1; end
      if (k == K_JALR) begin e.rf_src = 2'd2; e.pc_src = 2'd2; end
      push_step(k, f3, f75, fl, 1'b0, 1'b0, 1'b1, e);
      exp_retired++;
   endtask

   task automatic add_trap(input logic [1:0] cause, input int n);
      snap_t e;
      e = '0; e.trap = 1'b1; e.trap_cause = cause;
      for (int i = 0; i < n; i++) push_step(K_R, 3'd0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, e);
   endtask

   task automatic add_fetch_idle();
      snap_t e;
      e = '0; e.imem_re = 1'b1;
      push_step(K_R, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, e);
   endtask

   // Random branch: operands chosen first, flags and outcome derived from them.
   task automatic rand_branch(output logic [2:0] f3, output logic [3:0] fl, output logic taken);
      logic [31:0] a, b, d;
      logic [2:0]  tbl [6];
      tbl = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      d = a - b;
      fl[0] = (d == 32'd0);
      fl[1] = d[31];
      fl[2] = (a[31] != b[31]) && (d[31] != a[31]);
      fl[3] = (a >= b);
      f3 = tbl[$urandom_range(0, 5)];
      case (f3)
         3'd0:    taken = (a == b);
         3'd1:    taken = (a != b);
         3'd4:    taken = ($signed(a) < $signed(b));
         3'd5:    taken = ($signed(a) >= $signed(b));
         3'd6:    taken = (a < b);
         default: taken = (a >= b);
      endcase
   endtask

   task automatic rand_alu_fields(output logic [2:0] f3, output logic f75);
      f3  = 3'($urandom_range(0, 7));
      f75 = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic run_trace(input int n);
      int lim;
      lim = (n <= 0 || n > exp_q.size()) ? exp_q.size() : n;
      obs_q.delete();
      for (int i = 0; i < lim; i++) begin
         opcode     = exp_q[i].opcode;
         funct3     = exp_q[i].f3;
         funct7_5   = exp_q[i].f75;
         alu_flags  = exp_q[i].flags;
         imem_ready = exp_q[i].imr;
         dmem_ready = exp_q[i].dmr;
         @(negedge clk);
         obs_q.push_back(sample());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_retired = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      snap_t e;
      rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      opcode = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0; alu_flags = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (sample() !== 20'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %05h expected %05h", sample(), 20'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      e = '0; e.imem_re = 1'b1;
      n_checks++;
      if (sample() !== e) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %05h expected %05h", sample(), e);
      end
`ifdef PERF_CNT_EN
      n_checks++;
      if (retired_cnt !== CW'(0)) begin
         n_fail++;
         $display("[TB] FAIL reset_retired: got %0d expected 0", retired_cnt);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      do_reset();
      add_instr(K_R, 3'd0, 1'b0, 4'($urandom), 0, 0, 1'b0);
      add_fetch_idle();
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL add step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
   endtask

   task automatic test_alu();
      logic [2:0] f3;
      logic       f75;
      kind_t      k;
      do_reset();
      add_instr(K_R,     3'd0, 1'b1, 4'h0, 0, 0, 1'b0);
      add_instr(K_OPIMM, 3'd5, 1'b1, 4'h0, 0, 0, 1'b0);
      add_instr(K_OPIMM, 3'd0, 1'b1, 4'h0, 0, 0, 1'b0);
      for (int n = 0; n < 14; n++) begin
         k = ($urandom_range(0, 1) == 0) ? K_R : K_OPIMM;
         rand_alu_fields(f3, f75);
         add_instr(k, f3, f75, 4'($urandom), $urandom_range(0, 2), 0, 1'b0);
      end
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL alu step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
   endtask

   task automatic test_mem();
      do_reset();
      add_instr(K_LOAD,  3'd2, 1'b0, 4'h0, 3, 3, 1'b0);
      add_instr(K_LOAD,  3'd4, 1'b0, 4'h5, 0, 0, 1'b0);
      add_instr(K_STORE, 3'd2, 1'b0, 4'h0, 0, 0, 1'b0);
      add_instr(K_STORE, 3'd1, 1'b0, 4'hA, 1, 3, 1'b0);
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL mem step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3;
      logic [3:0] fl;
      logic       tk;
      do_reset();
      add_instr(K_BRANCH, 3'd0, 1'b0, 4'b0001, 0, 0, 1'b1);
      add_instr(K_BRANCH, 3'd0, 1'b0, 4'($urandom) & 4'b1110, 0, 0, 1'b0);
      add_instr(K_BRANCH, 3'd6, 1'b0, 4'($urandom) & 4'b0111, 0, 0, 1'b1);
      for (int n = 0; n < 14; n++) begin
         rand_branch(f3, fl, tk);
         add_instr(K_BRANCH, f3, 1'b0, fl, $urandom_range(0, 1), 0, tk);
      end
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL branch step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
   endtask

   task automatic test_jumps();
      do_reset();
      add_instr(K_JALR,  3'd0, 1'b0, 4'($urandom), 0, 0, 1'b0);
      add_instr(K_JAL,   3'($urandom), 1'b0, 4'($urandom), 1, 0, 1'b0);
      add_instr(K_AUIPC, 3'($urandom), 1'b0, 4'($urandom), 0, 0, 1'b0);
      add_instr(K_LUI,   3'($urandom), 1'b0, 4'($urandom), 2, 0, 1'b0);
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL jumps step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
   endtask

   task automatic test_illegal();
      for (int c = 0; c < 2; c++) begin
         do_reset();
         if (c == 0) add_instr(K_BAD, 3'd0, 1'b0, 4'h0, 0, 0, 1'b0);
         else        add_instr(K_BRANCH, 3'($urandom_range(2, 3)), 1'b0, 4'($urandom), 0, 0, 1'b0);
         add_trap(2'b01, 3);
         run_trace(0);
         for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i].exp) begin
               n_fail++;
               $display("[TB] FAIL illegal%0d step %0d: got %05h expected %05h", c, i, obs_q[i], exp_q[i].exp);
            end
         end
      end
   endtask

   task automatic test_timeout();
      snap_t e;
      for (int c = 0; c < 2; c++) begin
         do_reset();
         if (c == 0) begin
            e = '0; e.imem_re = 1'b1;
            for (int i = 0; i < TO; i++) push_step(K_R, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, e);
         end else begin
            add_instr(K_STORE, 3'd2, 1'b0, 4'h0, 0, -1, 1'b0);
         end
         add_trap(2'b10, 3);
         run_trace(0);
         for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i].exp) begin
               n_fail++;
               $display("[TB] FAIL timeout%0d step %0d: got %05h expected %05h", c, i, obs_q[i], exp_q[i].exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      snap_t e;
      do_reset();
      add_instr(K_R, 3'd4, 1'b0, 4'h0, 0, 0, 1'b0);
      add_instr(K_LOAD, 3'd2, 1'b0, 4'h0, 0, -1, 1'b0);
      run_trace(9);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL midmem step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (sample() !== 20'h0) begin
         n_fail++;
         $display("[TB] FAIL midmem_reset: got %05h expected %05h", sample(), 20'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
      exp_retired = 0;
      @(negedge clk);
      e = '0; e.imem_re = 1'b1;
      n_checks++;
      if (sample() !== e) begin
         n_fail++;
         $display("[TB] FAIL midmem_release: got %05h expected %05h", sample(), e);
      end
`ifdef PERF_CNT_EN
      n_checks++;
      if (retired_cnt !== CW'(exp_retired)) begin
         n_fail++;
         $display("[TB] FAIL midmem_retired: got %0d expected %0d", retired_cnt, exp_retired);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      kind_t      k;
      logic [2:0] f3;
      logic       f75;
      logic [3:0] fl;
      logic       tk;
      do_reset();
      for (int n = 0; n < 24; n++) begin
         k  = kind_t'($urandom_range(0, 8));
         f3 = 3'($urandom); f75 = 1'b0; fl = 4'($urandom); tk = 1'b0;
         if (k == K_R || k == K_OPIMM) rand_alu_fields(f3, f75);
         if (k == K_BRANCH) rand_branch(f3, fl, tk);
         add_instr(k, f3, f75, fl, $urandom_range(0, 3), $urandom_range(0, 3), tk);
      end
      run_trace(0);
      for (int i = 0; i < obs_q.size(); i++) if (exp_q[i].care) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i].exp) begin
            n_fail++;
            $display("[TB] FAIL b2b step %0d: got %05h expected %05h", i, obs_q[i], exp_q[i].exp);
         end
      end
`ifdef PERF_CNT_EN
      n_checks++;
      if (retired_cnt !== CW'(exp_retired)) begin
         n_fail++;
         $display("[TB] FAIL b2b_retired: got %0d expected %0d", retired_cnt, exp_retired);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu();
      test_mem();
      test_branch();
      test_jumps();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
